pipe_skid_reg: RTL

- Parametrised pipeline-stage register: the successor to the plain load-enable register used between RISC-V pipeline stages.
- Adds a valid/ready handshake, a two-entry skid buffer so upstream ready is fully registered, a synchronous flush, and a configurable bubble value on the output when empty.
- Sits between adjacent pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Lets a downstream stall propagate upstream with one cycle of slack and no combinational ready path.

---
 rtl/pipe_skid_reg_pkg.sv | 10 +
 rtl/pipe_skid_reg_data_reg_en.sv | 16 +
 rtl/pipe_skid_reg.sv | 53 +++++
 3 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// pipe_skid_reg_pkg: shared pipeline types, NOP encoding and per-stage payload widths
package pipe_skid_reg_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  // Payload widths of the inter-stage structs, passed as WIDTH when instantiating
  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 151;
  localparam int EX_MEM_W = 106;
  localparam int MEM_WB_W = 71;
endpackage

// File: rtl/pipe_skid_reg_data_reg_en.sv
// data_reg_en: load-enable register with sync reset and sync clear to RESET_VAL
module data_reg_en #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk)
    if (reset || clear) q <= RESET_VAL;
    else if (en) q <= d;
endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: valid/ready pipeline register with two-entry skid buffer, flush and output bubble
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [31:0] BUBBLE = NOP_INSTR,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);
  localparam logic [WIDTH-1:0] BUBBLE_W = WIDTH'(BUBBLE);
  state_t state, state_n;
  logic in_fire, out_fire, main_en, skid_en;
  logic [WIDTH-1:0] main_q, skid_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // Skid only fills when main is stalled; main refills from skid before taking new input
  assign main_en = (state == EMPTY && in_fire) || (state == ONE && in_fire && out_fire) ||
                   (state == TWO && out_fire);
  assign skid_en = state == ONE && in_fire && !out_fire;
  data_reg_en #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
    .clk(clk), .reset(reset), .clear(flush), .en(main_en),
    .d(state == TWO ? skid_q : in_data), .q(main_q)
  );
  data_reg_en #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
    .clk(clk), .reset(reset), .clear(flush), .en(skid_en),
    .d(in_data), .q(skid_q)
  );
  always_ff @(posedge clk)
    if (reset) state <= EMPTY;
    else state <= state_n;
  always_comb begin
    state_n = flush ? EMPTY :
              state == EMPTY ? (in_fire ? ONE : EMPTY) :
              state == ONE ? ((in_fire && !out_fire) ? TWO : (!in_fire && out_fire) ? EMPTY : ONE) :
              (out_fire ? ONE : TWO);
  end
  always_comb begin
    in_ready  = state != TWO;
    out_valid = state != EMPTY;
    out_data  = out_valid ? main_q : BUBBLE_W;
    occupancy = state;
  end
endmodule
